// File: rtl/risc_wait_controller.sv
// Phase sequencer for the 8-phase accumulator CPU, with memory wait states,
// a stall timeout that raises a sticky bus error, and a resumable HALTED state.
module risc_wait_controller #(
  parameter int ACK_EN     = 1,
  parameter int WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       Zero,
  input  logic       mem_ack,
  input  logic       resume,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic [2:0] phase,
  output logic       bus_err
);

  localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  state_t         state, state_next;
  opcode_t        op;
  logic [WCW-1:0] wait_cnt, wait_cnt_next;
  logic           bus_err_next;
  logic [2:0]     last_phase;
  logic           alu_op, wait_point, stalled, timeout;

  // Classify the current cycle: ALU-type opcode, wait point, stall and timeout
  always_comb begin
    op         = opcode_t'(opcode);
    alu_op     = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    wait_point = 1'b0;
    case (state)
      INST_FETCH: wait_point = 1'b1;
      OP_FETCH:   wait_point = alu_op;
      STORE:      wait_point = (op == OP_STO);
      default:    wait_point = 1'b0;
    endcase
    stalled = (ACK_EN != 0) && wait_point && !mem_ack;
    // The count is compared one short of the limit: the edge that would make
    // it reach WAIT_LIMIT is the edge that moves to HALTED.
    timeout = (WAIT_LIMIT > 0) && stalled && (wait_cnt == WCW'(WAIT_LIMIT - 1));
  end

  // Next-state, wait counter and bus error update
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    bus_err_next  = bus_err;
    case (state)
      HALTED: begin
        wait_cnt_next = '0;
        if (resume) state_next = INST_ADDR;
      end
      OP_ADDR: begin
        wait_cnt_next = '0;
        state_next    = (op == OP_HLT) ? HALTED : OP_FETCH;
      end
      default: begin
        if (timeout) begin
          state_next    = HALTED;
          wait_cnt_next = '0;
          bus_err_next  = 1'b1;
        end else if (stalled) begin
          if (WAIT_LIMIT > 0) wait_cnt_next = wait_cnt + 1'b1;
        end else begin
          state_next    = state_t'({1'b0, 3'(state[2:0] + 3'd1)});
          wait_cnt_next = '0;
        end
      end
    endcase
  end

  // State, wait counter, sticky error and last visible phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INST_ADDR;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      last_phase <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      bus_err  <= bus_err_next;
      if (state != HALTED) last_phase <= state[2:0];
    end
  end

  // Decoded control outputs and phase indication
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    phase   = state[2:0];
    case (state)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op == OP_HLT);
      end
      OP_FETCH: mem_rd = alu_op;
      ALU_OP: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (op == OP_SKZ) && Zero;
        load_pc = (op == OP_JMP);
      end
      STORE: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (op == OP_JMP);
        load_pc = (op == OP_JMP);
        mem_wr  = (op == OP_STO);
      end
      HALTED: begin
        halt  = 1'b1;
        phase = last_phase;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/risc_wait_controller.md
Name: risc_wait_controller

Overview:
- Next-generation sequencer for the 8-phase accumulator CPU; it drives mem_rd, load_ir, halt, inc_pc, load_ac, load_pc and mem_wr from the phase, opcode and Zero.
- Over the fixed-timing controller it adds:
  - memory wait states through a mem_ack handshake;
  - a configurable wait timeout with a sticky bus error;
  - a true HALTED state that is left only by a resume pulse.
- Sits between the instruction register/ALU flags and the memory/PC/AC load enables.

Parameters:
- ACK_EN, 1: 1 means memory phases stall until mem_ack; 0 means mem_ack is ignored (zero-wait, legacy timing).
- WAIT_LIMIT, 8: consecutive stalled cycles allowed before bus error; 0 disables the timeout. Counter width is clog2(WAIT_LIMIT+1), minimum 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- opcode  input  3  current IR opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- Zero  input  1  accumulator-zero flag
- mem_ack  input  1  memory transfer complete, sampled on the rising edge
- resume  input  1  single-cycle pulse; leaves HALTED
- mem_rd  output  1  memory read enable
- load_ir  output  1  instruction register load
- halt  output  1  halt indication
- inc_pc  output  1  PC increment
- load_ac  output  1  accumulator load
- load_pc  output  1  PC load
- mem_wr  output  1  memory write enable
- phase  output  3  current phase 0..7 (holds last phase while HALTED)
- bus_err  output  1  sticky timeout error

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - On rst: state=INST_ADDR, phase=0, wait counter=0, bus_err=0.
  - All decoded outputs are 0 during reset and in INST_ADDR.
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED. The phase output equals the state code for states 0–7.
- Advance: each state steps to the next (7 wraps to 0) after one cycle, except at wait points, HALT and error.
- ALUOP = opcode in {ADD, AND, XOR, LDA}. Outputs are combinational on state, opcode and Zero:
  - INST_FETCH: mem_rd=1.
  - INST_LOAD, IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && Zero), load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
  - HALTED: halt=1, all others 0.
- HLT: from OP_ADDR with opcode==HLT, the next state is HALTED (inc_pc pulses once in OP_ADDR). HALTED holds indefinitely.
  - resume=1 in HALTED: next state is INST_ADDR.
  - resume is ignored in every other state.
- Wait points (ACK_EN=1 only):
  - INST_FETCH always.
  - OP_FETCH when ALUOP.
  - STORE when opcode==STO.
  - Rule: the state advances only on an edge where mem_ack=1. Outputs stay asserted throughout the stall.
  - mem_ack outside a wait point is ignored.
  - ACK_EN=0: no stalls; timing is a fixed 8 cycles per instruction.
- Timeout:
  - The wait counter increments on each stalled cycle and clears on advance.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT while still stalled, the next state is HALTED and bus_err=1.
  - bus_err is sticky until rst; resume still restarts at INST_ADDR.
  - mem_ack arriving on the same edge that would reach the limit wins: the state advances and there is no error.
- Mid-operation: an asynchronous rst in any state, including a stall, returns to INST_ADDR immediately and clears bus_err.
- Opcode and Zero are not latched; the external IR holds opcode stable from INST_LOAD onward.

Test Plan:
- ACK_EN=0, rst pulse, opcode=ADD (2), Zero=0:
  - phase sequences 0..7 and wraps in 8 cycles.
  - mem_rd=1 in phases 1,2,3,5,6,7; load_ir=1 in 2,3; load_ac=1 in 6,7; inc_pc=1 in 4 only.
- opcode=HLT: halt=1 in phase 4, then HALTED with halt=1 held for 20 cycles; resume pulse leads to phase=0 on the next cycle.
- opcode=SKZ:
  - Zero=1: inc_pc=1 in phase 6.
  - Zero=0: inc_pc=0 in phase 6.
  - opcode=JMP: load_pc=1 in phases 6,7, inc_pc=1 in 7.
- ACK_EN=1, opcode=STO, mem_ack delayed 3 cycles at phase 1 and 2 cycles at phase 7:
  - the instruction takes 13 cycles.
  - mem_rd stays 1 during the phase-1 stall; mem_wr stays 1 during the phase-7 stall.
- WAIT_LIMIT=4, mem_ack held 0 at INST_FETCH: after 4 stalled cycles, HALTED with bus_err=1 and halt=1. Resume returns to phase 0 with bus_err still 1; rst clears it.
- Assert rst asynchronously mid-stall (phase=5): outputs go to 0 and phase=0 before the next clock edge.
